// File: rtl/ex_muldiv.sv
`timescale 1ns/1ps
// RV32M multiply/divide unit for the EX stage: two-cycle multiply, DATA_W-step
// restoring divide, registered write-back with a one-cycle done pulse.
module ex_muldiv #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] reg1,
  input  logic [DATA_W-1:0] reg2,
  input  logic [ADDR_W-1:0] wd_in,
  input  logic              wreg_in,
  input  logic              flush,
  output logic              stallreq,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] wd,
  output logic              wreg
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIV_RUN = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_quot, r_rem, r_divisor, r_result;
  logic              r_isRem, r_negQ, r_negR, r_done, r_wreg, r_wregCap;
  logic [ADDR_W-1:0] r_wd, r_wdCap;

  logic                w_divSigned, w_divZero, w_divOvf, w_mulASigned, w_mulBSigned;
  logic [2*DATA_W-1:0] w_mulA, w_mulB, w_prod;
  logic [DATA_W-1:0]   w_mulRes, w_specRes, w_absA, w_absB;
  logic [DATA_W:0]     w_shift, w_diff;
  logic                w_qBit;
  logic [DATA_W-1:0]   w_remNext, w_quotNext, w_remFix, w_quotFix;

  assign w_divSigned  = ~op[0];
  assign w_divZero    = (reg2 == '0);
  assign w_divOvf     = w_divSigned && (reg1 == {1'b1, {(DATA_W-1){1'b0}}}) && (reg2 == '1);
  assign w_mulASigned = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
  assign w_mulBSigned = (op[1:0] == 2'b01);

  // Extending both operands to 2*DATA_W lets one multiplier serve all signedness mixes.
  assign w_mulA   = {{DATA_W{w_mulASigned & reg1[DATA_W-1]}}, reg1};
  assign w_mulB   = {{DATA_W{w_mulBSigned & reg2[DATA_W-1]}}, reg2};
  assign w_prod   = w_mulA * w_mulB;
  assign w_mulRes = (op[1:0] == 2'b00) ? w_prod[DATA_W-1:0] : w_prod[2*DATA_W-1:DATA_W];

  assign w_specRes = w_divZero ? (op[1] ? reg1 : {DATA_W{1'b1}})
                               : (op[1] ? {DATA_W{1'b0}} : reg1);
  assign w_absA = (w_divSigned && reg1[DATA_W-1]) ? -reg1 : reg1;
  assign w_absB = (w_divSigned && reg2[DATA_W-1]) ? -reg2 : reg2;

  // Restoring step: r_quot shifts the dividend out MSB-first while collecting quotient bits.
  assign w_shift    = {r_rem, r_quot[DATA_W-1]};
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_qBit     = ~w_diff[DATA_W];
  assign w_remNext  = w_qBit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
  assign w_quotNext = {r_quot[DATA_W-2:0], w_qBit};
  assign w_quotFix  = r_negQ ? -w_quotNext : w_quotNext;
  assign w_remFix   = r_negR ? -w_remNext : w_remNext;

  assign stallreq = ((r_state == IDLE) && start) || (r_state == DIV_RUN);
  assign done     = r_done;
  assign result   = r_result;
  assign wd       = r_wd;
  assign wreg     = r_wreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_result  <= '0;
      r_isRem   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_done    <= 1'b0;
      r_wreg    <= 1'b0;
      r_wregCap <= 1'b0;
      r_wd      <= '0;
      r_wdCap   <= '0;
    end else begin
      r_done <= 1'b0;
      r_wreg <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_wdCap   <= wd_in;
              r_wregCap <= wreg_in;
              r_isRem   <= op[1];
              r_negQ    <= w_divSigned && (reg1[DATA_W-1] ^ reg2[DATA_W-1]);
              r_negR    <= w_divSigned && reg1[DATA_W-1];
              r_quot    <= w_absA;
              r_rem     <= '0;
              r_divisor <= w_absB;
              r_count   <= '0;
              if (!op[2] || w_divZero || w_divOvf) begin
                r_result <= op[2] ? w_specRes : w_mulRes;
                r_done   <= 1'b1;
                r_wd     <= wd_in;
                r_wreg   <= wreg_in;
                r_state  <= DONE;
              end else begin
                r_state <= DIV_RUN;
              end
            end
          end
          DIV_RUN: begin
            r_quot  <= w_quotNext;
            r_rem   <= w_remNext;
            r_count <= r_count + CNT_W'(1);
            if (r_count == CNT_W'(DATA_W - 1)) begin
              r_result <= r_isRem ? w_remFix : w_quotFix;
              r_done   <= 1'b1;
              r_wd     <= r_wdCap;
              r_wreg   <= r_wregCap;
              r_state  <= DONE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
`timescale 1ns/1ps
// Self-checking bench for ex_muldiv: directed corner cases, flush/reset aborts
// and randomized operations checked against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, flush, wreg_in;
  logic [2:0]  op;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd_in;
  logic        stallreq, done, wreg;
  logic [31:0] result;
  logic [4:0]  wd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .reg1(reg1), .reg2(reg2),
    .wd_in(wd_in), .wreg_in(wreg_in), .flush(flush), .stallreq(stallreq),
    .done(done), .result(result), .wd(wd), .wreg(wreg)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics from 64-bit arithmetic; SV division truncates toward zero.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2] || b == 0) return 1;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issues one instruction, holds it while stalled, then checks timing and write-back.
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] d, input logic w, input logic [31:0] expRes);
    int lat, n, stallBad;
    logic seen;
    lat = refLatency(f, a, b);
    n = 0;
    stallBad = 0;
    seen = 1'b0;
    @(negedge clk);
    op = f; reg1 = a; reg2 = b; wd_in = d; wreg_in = w; start = 1'b1;
    #1 checkOutput("stall_accept", stallreq, 1'b1);
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (stallreq !== (n < lat)) stallBad++;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    checkOutput("latency", n, lat);
    checkOutput("stall_profile", stallBad, 0);
    checkOutput("result", result, expRes);
    checkOutput("wd", wd, d);
    checkOutput("wreg", wreg, w);
    @(negedge clk);
    checkOutput("done_clear", {done, wreg}, 2'b00);
    checkOutput("result_hold", result, expRes);
  endtask

  task automatic countDones(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
  endtask

  logic [2:0]  dOp  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] dA   [12] = '{32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] dB   [12] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] dExp [12] = '{32'hFFFFFFEB, 32'h40000000, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                             32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  initial begin
    int pulses;
    logic [2:0]  f;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0;
    reg1 = '0; reg2 = '0; wd_in = '0; wreg_in = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {done, wreg, wd, result}, '0);
    checkOutput("reset_stall", stallreq, 1'b0);
    rst = 1'b0;

    applyStimulus(dOp[0], dA[0], dB[0], 5'd5, 1'b1, dExp[0]);
    for (int i = 1; i < 12; i++)
      applyStimulus(dOp[i], dA[i], dB[i], 5'(i), i[0], dExp[i]);

    // Flush mid-divide: no done for the aborted op, then a multiply goes through.
    @(negedge clk);
    op = 3'd4; reg1 = 32'd1000; reg2 = 32'd3; wd_in = 5'd7; wreg_in = 1'b1; start = 1'b1;
    countDones(9, pulses);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1 checkOutput("flush_idle", stallreq, 1'b0);
    checkOutput("flush_no_done", pulses + int'(done), 0);
    applyStimulus(3'd0, 32'd3, 32'd4, 5'd9, 1'b1, 32'd12);
    countDones(30, pulses);
    checkOutput("flush_no_late_done", pulses, 0);

    // Reset in cycle 20 of a divide.
    @(negedge clk);
    op = 3'd5; reg1 = 32'd12345; reg2 = 32'd17; wd_in = 5'd11; wreg_in = 1'b1; start = 1'b1;
    countDones(19, pulses);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_outputs", {done, wreg, wd, result}, '0);
    checkOutput("rst_mid_idle", stallreq, 1'b0);
    rst = 1'b0;
    countDones(20, pulses);
    checkOutput("rst_no_done", pulses, 0);

    // start held through DONE: one pulse, then re-accept after an IDLE cycle.
    @(negedge clk);
    op = 3'd0; reg1 = 32'd5; reg2 = 32'd6; wd_in = 5'd3; wreg_in = 1'b1; start = 1'b1;
    @(negedge clk);
    checkOutput("held_done1", {done, stallreq}, 2'b10);
    checkOutput("held_result", result, 32'd30);
    @(negedge clk);
    checkOutput("held_idle", {done, stallreq}, 2'b01);
    @(negedge clk);
    checkOutput("held_done2", done, 1'b1);
    start = 1'b0;
    @(negedge clk);
    checkOutput("held_clear", done, 1'b0);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pickOperand();
      b = pickOperand();
      applyStimulus(f, a, b, 5'($urandom), 1'($urandom), refModel(f, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
RV32M multiply/divide execution unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the operand values, destination register and write-enable that ID/EX latches for M-extension instructions. It runs a two-cycle multiply or an iterative radix-2 divide. While an operation is in flight it raises stallreq so the pipeline holds ID/EX stable, then presents a registered write-back result.

Parameters:
DATA_W, 32, operand/result width; divide iteration count equals DATA_W
ADDR_W, 5, register address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  level: ID/EX holds a valid M-extension instruction
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
reg1  in  DATA_W  rs1 value (multiplicand/dividend)
reg2  in  DATA_W  rs2 value (multiplier/divisor)
wd_in  in  ADDR_W  destination register
wreg_in  in  1  write-enable from ID/EX
flush  in  1  synchronous abort of the in-flight operation
stallreq  out  1  combinational pipeline stall request
done  out  1  registered; result valid this cycle
result  out  DATA_W  registered write-back data
wd  out  ADDR_W  registered destination, captured at accept
wreg  out  1  registered write-enable; equals captured wreg_in while done=1, else 0

Behaviour:
- States: IDLE, DIV_RUN, DONE.
- Reset (rst=1 at clk edge): state IDLE, counter 0, result 0, wd 0, wreg 0, done 0. Reset overrides flush and start at every state, including mid-divide.
- Accept: in IDLE with start=1, capture op, reg1, reg2, wd_in and wreg_in.
- MUL/MULH/MULHSU/MULHU:
  - Compute the 2*DATA_W product and go to DONE.
  - MUL returns the low half. MULH uses signed×signed, MULHSU signed rs1 × unsigned rs2, MULHU unsigned×unsigned; these return the high half.
- DIV/REM with divisor 0: quotient all-ones, remainder = dividend. Go straight to DONE.
- Signed DIV/REM with dividend 0x80000000 and divisor -1: quotient 0x80000000, remainder 0. Go straight to DONE.
- Other divides:
  - Take magnitudes (signed ops) and go to DIV_RUN.
  - One restoring shift-subtract step per cycle for exactly DATA_W cycles, counter 0..DATA_W-1, then DONE.
  - Sign fix-up is applied as the result is registered. Quotient is negative iff operand signs differ. Remainder takes the dividend's sign.
- Latency, with the accept cycle as cycle 0:
  - done=1 in cycle 1 for multiply and the divide special cases.
  - done=1 in cycle DATA_W+1 (33) for normal divides.
- DONE lasts exactly one cycle, then IDLE. start is ignored in DONE, because it still reflects the completing instruction. The next instruction is accepted in the following IDLE cycle.
- stallreq = (state==IDLE && start) || state==DIV_RUN. It is low in DONE so the pipeline advances on the done cycle.
- done, result, wd and wreg only change on DONE entry. done and wreg clear on DONE exit. result and wd hold their value.
- flush=1 (no rst):
  - Next state is IDLE and done is never asserted for the aborted operation.
  - A flush in the accept cycle discards the accept.
  - A flush on the DONE cycle still lets done=1 appear that cycle, since it is registered; the consumer is expected to gate it.
- start low in IDLE: stay IDLE, outputs unchanged except done=0 and wreg=0.

Test Plan:
- MUL 7 × 0xFFFFFFFD, wd_in=5, wreg_in=1 -> cycle 1: done=1, result=0xFFFFFFEB, wd=5, wreg=1; stallreq=1 in cycle 0 only.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU same operands -> 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> stallreq high cycles 0–32, done cycle 33, result 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> done cycle 1, result 0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, and the REM form -> 0, both in cycle 1.
- DIV started, flush pulsed in cycle 10 -> no done, IDLE next cycle. A MUL 3×4 presented next is accepted and gives done=1, result=12, one cycle later.
- rst asserted in cycle 20 of a divide -> the next cycle shows all outputs 0 and state IDLE. start held across DONE -> only one done pulse, and re-acceptance waits one IDLE cycle.
